// File: rtl/mult_pkg.sv
// Shared widths and FSM state type for the shift-and-add multiplier.
// Used by shift_add_mult and bit_shift.
package mult_pkg;
  localparam int A_W   = 24;
  localparam int B_W   = 16;
  localparam int P_W   = 48;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/shift_add_mult_bit_shift.sv
// Barrel shifter: mod=0 shifts A left by n, mod=1 shifts right.
// A is zero-extended to the P_W-bit result.
module bit_shift
  import mult_pkg::*;
(
  input  logic [A_W-1:0]   A,
  input  logic [CNT_W-1:0] n,
  input  logic             mod,
  output logic [P_W-1:0]   S
);
  logic [P_W-1:0] ext;

  assign ext = P_W'(A);

  always_comb begin
    S = ext << n;
    if (mod) S = ext >> n;
  end
endmodule

// File: rtl/shift_add_mult.sv
// Sequential 24x16 unsigned shift-and-add multiplier, one partial product per cycle.
// Optional early exit when remaining multiplier bits are zero: SHIFT_ADD_MULT_EARLY_EN.
module shift_add_mult
  import mult_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [P_W-1:0] p
);
  state_t state, state_nxt;

  logic [A_W-1:0]   a_r;
  logic [B_W-1:0]   b_r;
  logic [P_W-1:0]   acc;
  logic [P_W-1:0]   acc_nxt;
  logic [P_W-1:0]   s;
  logic [CNT_W-1:0] k;
  logic             accept;
  logic             last;

  bit_shift u_shift (
    .A   (a_r),
    .n   (k),
    .mod (1'b0),
    .S   (s)
  );

  assign acc_nxt = b_r[k] ? acc + s : acc;

`ifdef SHIFT_ADD_MULT_EARLY_EN
  logic [CNT_W:0] k_inc;
  assign k_inc = {1'b0, k} + 1'b1;
  // Stop as soon as no set multiplier bits remain above k.
  assign last = (k == CNT_W'(B_W - 1)) || ((b_r >> k_inc) == '0);
`else
  assign last = (k == CNT_W'(B_W - 1));
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        accept = start;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        accept    = start;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      k   <= '0;
      p   <= '0;
    end else if (accept) begin
      a_r <= a;
      b_r <= b;
      acc <= '0;
      k   <= '0;
    end else if (busy) begin
      acc <= acc_nxt;
      k   <= k + 1'b1;
      if (last) p <= acc_nxt;
    end
  end
endmodule

// File: tb/tb_shift_add_mult.sv
// Directed self-checking bench for shift_add_mult.
// Build with +define+SHIFT_ADD_MULT_EARLY_EN to check the early-exit timing.
module tb_shift_add_mult;
  import mult_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic           busy;
  logic           done;
  logic [P_W-1:0] p;

  int errors = 0;
  int checks = 0;

  shift_add_mult dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  int             op_done;
  int             op_busy;
  int             op_both;
  logic [P_W-1:0] op_p;

  // Pulse start for one edge, then wait for done (bounded).
  // Cycle 1 is the period right after the accepting edge.
  task automatic run_op(input logic [A_W-1:0] av,
                        input logic [B_W-1:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = '1;
    b = '1;
    op_done = -1;
    op_busy = 0;
    op_both = 0;
    op_p = '0;
    for (int c = 1; c <= 40; c++) begin
      if (busy) op_busy++;
      if (busy && done) op_both++;
      if (done) begin
        op_done = c;
        op_p = p;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (p !== '0) begin
      errors++;
      $display("FAIL reset_p: got %h want 0", p);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    run_op(24'd3, 16'd5);
    checks++;
    if (op_done !== 17) begin
      errors++;
      $display("FAIL basic_latency: got %0d want 17", op_done);
    end
    checks++;
    if (op_p !== 48'd15) begin
      errors++;
      $display("FAIL basic_p: got %h want %h", op_p, 48'd15);
    end
    checks++;
    if (op_busy !== 16 || op_both !== 0) begin
      errors++;
      $display("FAIL basic_busy: busy cycles %0d overlap %0d want 16 0",
               op_busy, op_both);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (p !== 48'd15 || done !== 1'b0) begin
        errors++;
        $display("FAIL basic_hold: p=%h done=%b want f 0", p, done);
      end
    end
  endtask

  task automatic test_max;
    run_op(24'hFFFFFF, 16'hFFFF);
    checks++;
    if (op_p !== 48'h00FFFEFF0001 || op_done !== 17) begin
      errors++;
      $display("FAIL max: p=%h at %0d want 00fffeff0001 at 17",
               op_p, op_done);
    end
  endtask

  task automatic test_early;
    int want;
`ifdef SHIFT_ADD_MULT_EARLY_EN
    want = 4;
`else
    want = 17;
`endif
    run_op(24'h10, 16'h0004);
    checks++;
    if (op_p !== 48'h40 || op_done !== want) begin
      errors++;
      $display("FAIL early_b4: p=%h at %0d want 40 at %0d",
               op_p, op_done, want);
    end
`ifdef SHIFT_ADD_MULT_EARLY_EN
    want = 2;
`else
    want = 17;
`endif
    run_op(24'h123456, 16'h0000);
    checks++;
    if (op_p !== 48'h0 || op_done !== want) begin
      errors++;
      $display("FAIL early_b0: p=%h at %0d want 0 at %0d",
               op_p, op_done, want);
    end
  endtask

  task automatic test_start_while_busy;
    int dc;
    logic [P_W-1:0] pv;
    @(negedge clk);
    a = 24'd2;
    b = 16'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dc = -1;
    pv = '0;
    for (int c = 1; c <= 40; c++) begin
      start = (c == 5);
      if (c == 5) begin
        a = 24'd7;
        b = 16'd7;
      end
      if (done) begin
        dc = c;
        pv = p;
        break;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    checks++;
    if (dc !== 17 || pv !== 48'd6) begin
      errors++;
      $display("FAIL busy_start: p=%h at %0d want 6 at 17", pv, dc);
    end
  endtask

  task automatic test_back_to_back;
    int d1, d2;
    logic [P_W-1:0] p1, p2;
    @(negedge clk);
    a = 24'd4;
    b = 16'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    d1 = -1;
    d2 = -1;
    p1 = '0;
    p2 = '0;
    for (int c = 1; c <= 60; c++) begin
      if (done && d1 < 0) begin
        d1 = c;
        p1 = p;
      end else if (done) begin
        d2 = c;
        p2 = p;
        break;
      end
      if (c == 33) start = 1'b0;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    checks++;
    if (d1 !== 17 || p1 !== 48'd16) begin
      errors++;
      $display("FAIL b2b_first: p=%h at %0d want 10 at 17", p1, d1);
    end
    checks++;
    if (d2 !== 34 || p2 !== 48'd16) begin
      errors++;
      $display("FAIL b2b_second: p=%h at %0d want 10 at 34", p2, d2);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    a = 24'd9;
    b = 16'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c < 8; c++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || p !== '0) begin
      errors++;
      $display("FAIL rst_mid: busy=%b done=%b p=%h want 0 0 0",
               busy, done, p);
    end
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || busy) seen++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_mid_quiet: active cycles %0d want 0", seen);
    end
    run_op(24'd9, 16'd9);
    checks++;
    if (op_p !== 48'd81 || op_done !== 17) begin
      errors++;
      $display("FAIL rst_mid_rerun: p=%h at %0d want 51 at 17",
               op_p, op_done);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_max;
    test_early;
    test_start_while_busy;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

Sequential 24×16 unsigned shift-and-add multiplier that drives the team's `bit_shift` block and consumes its 48-bit output. Each cycle it:
- generates one partial product, `A << i`, through the shifter (`mod` = 0);
- adds that partial product into a 48-bit accumulator.

It sits between operand-entry logic (DIP/switch inputs) and the product display or register stage, and uses start/busy/done handshaking.

## Interface
- A_W, 24, multiplicand width; must match the `bit_shift` A input.
- B_W, 16, multiplier width; at most 16 because the shift count is 4 bits.
- P_W, 48, product width; must match the `bit_shift` S output.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  request a multiply; sampled only when the block is not busy.
- a  input  A_W  multiplicand; captured on an accepted start.
- b  input  B_W  multiplier; captured on an accepted start.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when p becomes valid.
- p  output  P_W  product; holds its value until the next done.

## Operation
- States are IDLE, RUN and DONE.
- **Accepted start:** state is IDLE or DONE and start = 1. On acceptance:
  - a_r ← a, b_r ← b, acc ← 0, k ← 0;
  - next state is RUN.
- **RUN cycle k** (k = 0..15):
  - if b_r[k] = 1, acc ← acc + S, where S = `bit_shift`(A = a_r, n = k, mod = 0);
  - otherwise acc is unchanged;
  - k ← k + 1.
- **Leaving RUN:** when k = 15, next state is DONE, and p is loaded with the final accumulator value at that same edge.
- **DONE:** lasts exactly one cycle, with done = 1. It returns to IDLE unless a start is accepted in that cycle, in which case it goes directly to RUN.
- **start while busy** (RUN): ignored; there is no queueing and the operands are not recaptured.
- **Inputs a and b** may change freely after the accepting edge.
- **Width rules:**
  - unsigned arithmetic throughout;
  - the maximum product is (2^24 − 1)(2^16 − 1) < 2^40, so the 48-bit accumulator cannot overflow;
  - the upper 8 bits of p are always 0.
- **Reset:** rst = 1 at any edge, including mid-RUN, forces:
  - state = IDLE, busy = 0, done = 0;
  - p = 0, acc = 0, k = 0;
  - the operation in progress is discarded and no done is issued.

## Timing
- Start sampled at edge T. RUN occupies cycles T+1..T+16 and done is high in cycle T+17; latency is 17 cycles.
- busy = 1 exactly in RUN cycles. busy and done are never high together.
- p changes only on the edge that enters DONE, or on reset.
- Back-to-back operation (start held in DONE) gives a throughput of one result per 17 cycles.
- Reset values: busy = 0, done = 0, p = 0.

## Configuration
- Macro: `SHIFT_ADD_MULT_EARLY_EN`.
- **Defined:** RUN cycle k also exits to DONE when b_r >> (k+1) = 0. Latency is 2 + (index of the highest set bit of b), and b = 0 gives done at T+2.
- **Undefined:** the fixed 16 RUN cycles always apply, with done at T+17. The product value is identical in both builds.

## Structure
- Shared package `mult_pkg` holds:
  - constants A_W, B_W, P_W, CNT_W = 4;
  - the state enum type (IDLE, RUN, DONE).
- One sub-module: an instance of the existing `bit_shift`, with mod tied to 0 and n driven by k.
- The adder, accumulator, counter and FSM live in the top level.

## Test plan
- **Basic multiply:** a = 3, b = 5, start pulsed at T → busy in T+1..T+16, done in T+17, p = 15. Then p holds 15 with done = 0 for 3 more cycles.
- **Maximum operands:** a = 0xFFFFFF, b = 0xFFFF → p = 0x00FFFEFF0001, done at T+17.
- **Early exit:** a = 0x10, b = 0x0004 → p = 0x40. done at T+4 with the macro defined, T+17 without. With b = 0 and the macro defined → p = 0, done at T+2.
- **Start while busy:** start a = 2, b = 3. Pulse start again at T+5 with a = 7, b = 7 → the second start is ignored, done only at T+17, p = 6.
- **Back-to-back:** hold start high with a = 4, b = 4 through the DONE cycle → first done gives p = 16, the second op is accepted at T+17, and the second done arrives at T+34.
- **Reset mid-operation:** rst at T+8 of a = 9, b = 9 → next cycle busy = 0, done = 0, p = 0, and no done follows. A fresh start then completes normally with p = 81.
